// File: rtl/bool_lut_pipe.sv
// Two-stage valid/ready pipeline that evaluates NCH runtime-programmable
// NIN-input boolean functions, each held as a 2^NIN-bit truth table.
module bool_lut_pipe #(
  parameter int unsigned NIN = 4,
  parameter int unsigned NCH = 2,
  parameter logic [(1 << NIN)-1:0] DEF_TT = 16'hFC00,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NIN-1:0]   in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NCH-1:0]   out_y,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_ch,
  input  logic [NIN-1:0]   cfg_addr,
  input  logic             cfg_bit,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned TTW = 1 << NIN;

  logic [NCH-1:0][TTW-1:0] tt;
  logic [NIN-1:0]          s1Data;
  logic                    s1Valid;
  logic                    s2Free;
  logic                    s1Adv;
  logic                    inFire;
  logic [NCH-1:0]          lookY;

  assign s2Free   = !out_valid || out_ready;
  assign s1Adv    = s1Valid && s2Free;
  assign in_ready = !s1Valid || s2Free;
  assign inFire   = in_valid && in_ready;

  // Per-channel match on cfg_ch makes out-of-range channels fall through untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NCH; k++) tt[k] <= DEF_TT;
    end else if (cfg_we) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        if (cfg_ch == 3'(k)) tt[k][cfg_addr] <= cfg_bit;
      end
    end
  end

  always_comb begin
    lookY = '0;
    for (int unsigned k = 0; k < NCH; k++) lookY[k] = tt[k][s1Data];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1Valid <= 1'b0;
      s1Data  <= '0;
    end else if (inFire) begin
      s1Valid <= 1'b1;
      s1Data  <= in_data;
    end else if (s1Adv) begin
      s1Valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (s1Adv) begin
      out_valid <= 1'b1;
      out_y     <= lookY;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) beat_cnt <= '0;
    else if (out_valid && out_ready) beat_cnt <= beat_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_bool_lut_pipe.sv
// Scoreboard bench for bool_lut_pipe: driver queues hand-computed results,
// an independent monitor pops and compares on every output beat.
module tb_bool_lut_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  out_y;
  logic        cfg_we;
  logic [2:0]  cfg_ch;
  logic [3:0]  cfg_addr;
  logic        cfg_bit;
  logic [15:0] beat_cnt;

  bool_lut_pipe #(.NIN(4), .NCH(2), .DEF_TT(16'hFC00), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_addr(cfg_addr), .cfg_bit(cfg_bit),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] y;
    int         acc;
    bit         lat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   expBeats = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got y=%0h with empty scoreboard", out_y);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_y", 32'(out_y), 32'(e.y));
        if (e.lat) chk("latency", 32'(cyc), 32'(e.acc + 2));
      end
    end
  end

  task automatic sendVec(input logic [3:0] d, input logic [1:0] y, input bit lat);
    bit accepted;
    accepted = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{y, cyc, lat});
        expBeats++;
        accepted = 1'b1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("accept_timeout", 32'(accepted), 32'd1);
  endtask

  task automatic cfgWrite(input logic [2:0] ch, input logic [3:0] a, input logic b);
    cfg_we = 1'b1; cfg_ch = ch; cfg_addr = a; cfg_bit = b;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  task automatic waitDrain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(posedge clk); #1;
      if (q.size() == 0) done = 1'b1;
    end
    chk("drain_timeout", 32'(done), 32'd1);
    chk("beat_cnt", 32'(beat_cnt), 32'(expBeats));
  endtask

  logic [15:0] par = 16'h6996;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_addr = '0; cfg_bit = 1'b0;
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", 32'(out_y), 32'd0);
    chk("rst_beat_cnt", 32'(beat_cnt), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Default function sweep: only 10..15 true on both channels
    for (int i = 0; i < 16; i++) sendVec(4'(i), (i >= 10) ? 2'b11 : 2'b00, 1'b1);
    waitDrain();

    // Reprogram ch1 to parity
    for (int i = 0; i < 16; i++) cfgWrite(3'd1, 4'(i), par[i]);
    sendVec(4'b0111, 2'b10, 1'b1);
    waitDrain();

    // Backpressure: 12 -> 01, 7 -> 10, 11 -> 11
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 4'd12;
    @(negedge clk);
    chk("bp_ready1", 32'(in_ready), 32'd1);
    if (in_ready) begin q.push_back('{2'b01, cyc, 1'b0}); expBeats++; end
    @(posedge clk); #1 in_data = 4'd7;
    @(negedge clk);
    chk("bp_ready2", 32'(in_ready), 32'd1);
    if (in_ready) begin q.push_back('{2'b10, cyc, 1'b0}); expBeats++; end
    @(posedge clk); #1 in_data = 4'd11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_full_ready", 32'(in_ready), 32'd0);
      chk("bp_hold_valid", 32'(out_valid), 32'd1);
      chk("bp_hold_y", 32'(out_y), 32'h1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drain_ready", 32'(in_ready), 32'd1);
    if (in_ready) begin q.push_back('{2'b11, cyc, 1'b0}); expBeats++; end
    @(posedge clk); #1 in_valid = 1'b0;
    waitDrain();

    // Write/lookup collision on tt[0][5]; ch1 parity(5)=0
    cfgWrite(3'd0, 4'd5, 1'b1);
    sendVec(4'd5, 2'b01, 1'b1);
    cfgWrite(3'd0, 4'd5, 1'b0);
    sendVec(4'd5, 2'b00, 1'b1);
    waitDrain();

    // Illegal channel writes must change nothing
    for (int i = 0; i < 16; i++) cfgWrite(3'd7, 4'(i), (i < 10));
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = 4'(i);
      sendVec(v, {^v, (i >= 10)}, 1'b1);
    end
    waitDrain();

    // Reset with two vectors in flight
    out_ready = 1'b0;
    sendVec(4'd3, 2'b00, 1'b0);
    sendVec(4'd13, 2'b11, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_y", 32'(out_y), 32'd0);
    chk("mid_rst_beat_cnt", 32'(beat_cnt), 32'd0);
    q.delete();
    expBeats = 0;
    @(posedge clk); #1 rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_valid0", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    chk("post_rst_valid1", 32'(out_valid), 32'd0);
    // ch1 must be back to the default table
    for (int i = 0; i < 16; i++) sendVec(4'(i), (i >= 10) ? 2'b11 : 2'b00, 1'b1);
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bool_lut_pipe.md
# bool_lut_pipe

Parametrised, pipelined successor to the fixed four-input switch-level boolean function. Each of NCH channels evaluates a runtime-programmable NIN-input boolean function, stored as a truth table, on a stream of input vectors. Flow is controlled by valid/ready on input and output. Reset loads every channel with DEF_TT; with the default parameters that is Y = A·(B+C) + A·C·D, where A = in_data[3] and D = in_data[0].

## Interface
- NIN, 4, inputs per function (2..6); truth table holds 2^NIN bits
- NCH, 2, number of independent output channels (1..8)
- DEF_TT, 16'hFC00, reset truth table loaded into every channel, width 2^NIN; bit i = f(in_data == i)
- CNT_W, 16, width of output beat counter
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input vector valid
- in_ready  out  1  block accepts a vector this cycle
- in_data  in  NIN  input vector
- out_valid  out  1  out_y valid
- out_ready  in  1  downstream accepts out_y
- out_y  out  NCH  function results, bit k = channel k
- cfg_we  in  1  truth-table bit write strobe
- cfg_ch  in  3  target channel
- cfg_addr  in  NIN  truth-table index
- cfg_bit  in  1  value written
- beat_cnt  out  CNT_W  count of output beats accepted downstream

## Operation
- Stage 1 (S1) registers in_data and s1_valid on an input handshake, i.e. in_valid & in_ready.
- Stage 2 (S2) performs the lookup tt[k][s1_data] for every k when S1 advances, and registers out_y and out_valid.
- Advance rules:
  - s2_free = !out_valid | out_ready.
  - S1 → S2 when s1_valid & s2_free.
  - in_ready = !s1_valid | s2_free. This is combinational from out_ready and out_valid.
- Holding:
  - When out_valid & !out_ready, out_y and out_valid hold.
  - S1 holds its data until it moves to S2.
  - No vector is dropped or duplicated.
- Config writes:
  - When cfg_we=1 and cfg_ch<NCH, tt[cfg_ch][cfg_addr] <= cfg_bit.
  - When cfg_ch>=NCH, the write is ignored with no side effects.
  - Writes are accepted every cycle, independent of the data handshakes.
- Write/lookup ordering: a write at edge t is seen by lookups at edge t+1 and later. A lookup on the same edge as a write uses the old bit.
- beat_cnt increments on each out_valid & out_ready cycle and wraps modulo 2^CNT_W.

## Timing
- Reset (async, immediate):
  - s1_valid=0, out_valid=0, out_y=0, beat_cnt=0.
  - Every tt[k]=DEF_TT.
  - in_ready=1 while reset is deasserted and the pipe is empty.
- Latency: a vector accepted on cycle n appears on out_y with out_valid=1 in cycle n+2 when there is no backpressure.
- Throughput: one vector per cycle when out_ready is held high.
- Backpressure buffering: with out_ready=0, the pipe holds two vectors (S1 and S2). in_ready drops in the cycle after the second acceptance.
- Drain: when out_ready rises while the pipe is full, in_ready=1 in the same cycle. Simultaneous output, S1→S2 move and input acceptance are legal.
- Reset mid-stream:
  - Aborts all in-flight vectors and discards them.
  - Restores DEF_TT, discarding prior config.
  - No out_valid in the cycle after reset is released.
- Outputs out_valid, out_y and beat_cnt are registered. in_ready is the only combinational output.

## Test plan
- Default function:
  - After reset, stream in_data 0..15 with out_ready=1.
  - Required: out_y[0] = out_y[1] = 1 only for inputs 10..15.
  - Each result appears 2 cycles after acceptance.
  - beat_cnt=16 at the end.
- Reprogram:
  - Write ch1 truth table to XOR-parity (16'h6996), 16 writes.
  - Then send 4'b0111.
  - Required: out_y = 2'b10 (ch0 = 0 via default, ch1 = 1).
- Backpressure:
  - Hold out_ready=0 and offer 3 vectors.
  - Required: two are accepted, in_ready=0 on the third.
  - Release out_ready: results emerge in order with no loss or duplication.
- Write/lookup collision:
  - Write tt[0][5]=0 on the same edge as vector 5 moves S1→S2.
  - Required: that result uses the old bit (1 with default, since 5 → A=0 gives 0; preload tt[0][5]=1 first).
  - The next vector 5 gives 0.
- Illegal channel: cfg_ch=7 with NCH=2 leaves both truth tables unchanged; verify with a full 0..15 sweep.
- Reset mid-stream:
  - Assert rst with 2 vectors in flight.
  - Required: out_valid=0 immediately, beat_cnt=0, tables back to DEF_TT, and no stale result after release.
